// File: rtl/rom_loader.sv
// Byte-stream ROM loader: takes a little-endian 32-bit word count followed by
// that many little-endian words and writes them to consecutive ROM words.
module rom_loader #(
    parameter int MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        accept;
    logic [31:0] word_full;

    assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
    assign we_o         = (state_q == S_WRITE);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;
    assign addr_o       = addr_q;
    assign data_o       = data_q;

    assign accept    = byte_valid_i && byte_ready_o;
    // The 4th byte completes the word in the same cycle it is accepted.
    assign word_full = {byte_i, asm_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;

        if (accept) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    asm_d[7:0]   = byte_i;
                2'd1:    asm_d[15:8]  = byte_i;
                2'd2:    asm_d[23:16] = byte_i;
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                    cnt_d   = 2'd0;
                    idx_d   = 32'd0;
                end
            end
            S_LEN: begin
                if (accept && cnt_q == 2'd3) begin
                    if (word_full == 32'd0 || word_full > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = word_full;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Address/data registers only change on a real write, so they
                // hold the last written values while we_o is low.
                if (accept && cnt_q == 2'd3) begin
                    addr_d  = {idx_q[29:0], 2'b00};
                    data_d  = word_full;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = (idx_q + 32'd1 == len_q) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            asm_q   <= 24'd0;
            len_q   <= 32'd0;
            idx_q   <= 32'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a negedge monitor logs writes, done pulses and
// accepted bytes; the linear sequence compares them with hand-derived values.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_ready_o, we_o, busy_o, done_o, err_o;
    logic [31:0] addr_o, data_o;

    rom_loader #(.MAX_WORDS(4096)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i),
        .byte_ready_o(byte_ready_o), .we_o(we_o), .addr_o(addr_o),
        .data_o(data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int rdy_in_wr = 0;
    int done_cyc = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cyc  [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (we_o) begin
                wr_addr[wr_cnt] = addr_o;
                wr_data[wr_cnt] = data_o;
                wr_cyc[wr_cnt]  = cyc;
                wr_cnt++;
                if (byte_ready_o) rdy_in_wr++;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (byte_valid_i && byte_ready_o) acc_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b1;
        byte_i = b;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = byte_ready_o;
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b0;
        if (!ok) chk("send_timeout", {31'd0, byte_ready_o}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(8'(w >> (8 * k)), 0);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_o; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    int base, dbase, abase;

    initial begin
        #3;
        chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
        chk("rst_we",    {31'd0, we_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_err",   {31'd0, err_o}, 32'd0);
        chk("rst_addr",  addr_o, 32'd0);
        chk("rst_data",  data_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two words back-to-back
        do_start();
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        wait_idle();
        chk("t1_nwr",   wr_cnt, 32'd2);
        chk("t1_a0",    wr_addr[0], 32'h0);
        chk("t1_d0",    wr_data[0], 32'h0000_0013);
        chk("t1_a1",    wr_addr[1], 32'h4);
        chk("t1_d1",    wr_data[1], 32'h0010_0093);
        chk("t1_rate",  wr_cyc[1] - wr_cyc[0], 32'd5);
        chk("t1_done",  done_cnt, 32'd1);
        chk("t1_dcyc",  done_cyc - wr_cyc[1], 32'd1);
        chk("t1_hold_a", addr_o, 32'h4);
        chk("t1_hold_d", data_o, 32'h0010_0093);
        chk("t1_err",   {31'd0, err_o}, 32'd0);

        // Zero length
        base = wr_cnt; dbase = done_cnt;
        do_start();
        send_word(32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_err",  {31'd0, err_o}, 32'd1);
        chk("t2_busy", {31'd0, busy_o}, 32'd0);
        chk("t2_nwr",  wr_cnt - base, 32'd0);
        chk("t2_done", done_cnt - dbase, 32'd0);

        // Length one past the limit, then restart clears err
        do_start();
        send_word(32'd4097);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_err",  {31'd0, err_o}, 32'd1);
        chk("t3_nwr",  wr_cnt - base, 32'd0);
        do_start();
        chk("t3_clr",  {31'd0, err_o}, 32'd0);

        // N=1 with gaps, valid byte held through WRITE/DONE
        send_word(32'd1);
        send(8'hAA, 3); send(8'hBB, 3); send(8'hCC, 3); send(8'hDD, 3);
        abase = acc_cnt;
        byte_valid_i = 1'b1; byte_i = 8'hEE;
        chk("t4_we",    {31'd0, we_o}, 32'd1);
        chk("t4_rdy",   {31'd0, byte_ready_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        chk("t4_nacc",  acc_cnt - abase, 32'd0);
        chk("t4_nwr",   wr_cnt - base, 32'd1);
        chk("t4_a",     wr_addr[base], 32'h0);
        chk("t4_d",     wr_data[base], 32'hDDCC_BBAA);
        chk("t4_done",  done_cnt - dbase, 32'd1);
        chk("t4_rdywr", rdy_in_wr, 32'd0);

        // Reset mid-word
        base = wr_cnt; dbase = done_cnt;
        do_start();
        send_word(32'd1);
        send(8'h11, 0); send(8'h22, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_rdy",  {31'd0, byte_ready_o}, 32'd0);
        chk("t5_addr", addr_o, 32'd0);
        chk("t5_data", data_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_nwr0", wr_cnt - base, 32'd0);
        do_start();
        send_word(32'd1);
        send_word(32'h1234_5678);
        wait_idle();
        chk("t5_nwr",  wr_cnt - base, 32'd1);
        chk("t5_a",    wr_addr[base], 32'h0);
        chk("t5_d",    wr_data[base], 32'h1234_5678);
        chk("t5_done", done_cnt - dbase, 32'd1);

        // start_i pulsed during DATA is ignored
        base = wr_cnt; dbase = done_cnt;
        do_start();
        send_word(32'd3);
        send_word(32'd1);
        send(8'h02, 0);
        do_start();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send_word(32'd3);
        wait_idle();
        chk("t6_nwr",  wr_cnt - base, 32'd3);
        chk("t6_a0",   wr_addr[base],     32'h0);
        chk("t6_a1",   wr_addr[base + 1], 32'h4);
        chk("t6_a2",   wr_addr[base + 2], 32'h8);
        chk("t6_d1",   wr_data[base + 1], 32'd2);
        chk("t6_d2",   wr_data[base + 2], 32'd3);
        chk("t6_done", done_cnt - dbase, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
